// File: rtl/spawn_pkg.sv
// Shared types and constants for the meteor spawn scheduler and its LFSR.
package spawn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    GRANT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Polynomial x^16+x^14+x^13+x^11+1 expressed as right-shift feedback taps (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int DEFAULT_X_MIN = 25;
  localparam int DEFAULT_X_MAX = 605;

  function automatic int calc_ceff(input int cooldown, input int lvl);
    int c;
    c = cooldown - lvl;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, synchronously reset to the package seed.
module spawn_lfsr
  import spawn_pkg::*;
(
  input  logic        frame_clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic feedback;

  assign feedback = ^(value & LFSR_TAPS);

  always_ff @(posedge frame_clk) begin
    if (reset) value <= LFSR_SEED;
    else       value <= {feedback, value[15:1]};
  end

endmodule

// File: rtl/meteor_spawn_scheduler.sv
// Round-robin meteor respawn arbiter with cooldown spacing and LFSR-driven spawn payload.
// Define SPAWN_DIFFICULTY_EN to let kills raise the difficulty level.
module meteor_spawn_scheduler
  import spawn_pkg::*;
#(
  parameter int OBJ_NUM         = 4,
  parameter int COOLDOWN        = 8,
  parameter int X_MIN           = DEFAULT_X_MIN,
  parameter int X_MAX           = DEFAULT_X_MAX,
  parameter int KILLS_PER_LEVEL = 8,
  parameter int MAX_LEVEL       = 7
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic [OBJ_NUM-1:0] spawn_req,
  input  logic               bullet_hit,
  output logic [OBJ_NUM-1:0] spawn_grant,
  output logic [9:0]         spawn_x,
  output logic [4:0]         spawn_y_speed,
  output logic [4:0]         spawn_x_speed,
  output logic               spawn_sign,
  output logic [2:0]         level,
  output logic [7:0]         kill_count
);

  localparam int PTR_W = (OBJ_NUM > 1) ? $clog2(OBJ_NUM) : 1;
  localparam int CNT_W = $clog2(COOLDOWN + 1);
  localparam int RANGE = X_MAX - X_MIN + 1;

  if (COOLDOWN < 1 || MAX_LEVEL > 7 || KILLS_PER_LEVEL < 1) begin : g_bad_params
    $error("meteor_spawn_scheduler: illegal parameter combination");
  end

  state_t               state, next_state;
  logic [PTR_W-1:0]     ptr;
  logic [CNT_W-1:0]     counter;
  logic [CNT_W-1:0]     ceff;
  logic [15:0]          lfsr_value;
  logic [2*OBJ_NUM-1:0] req_dbl;
  logic [OBJ_NUM-1:0]   req_rot;
  logic                 found;
  logic [PTR_W-1:0]     winner;
  logic [OBJ_NUM-1:0]   winner_onehot;
  logic [9:0]           raw;
  logic [9:0]           x_offset;
  logic [5:0]           y_sum;
  logic [4:0]           y_speed_next;
  logic                 hit_counted;

  spawn_lfsr u_lfsr (
    .frame_clk (frame_clk),
    .reset     (Reset),
    .value     (lfsr_value)
  );

  always_ff @(posedge frame_clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = READY;
        READY:   if (found) next_state = GRANT;
        GRANT:   next_state = HOLD;
        HOLD:    if (counter == CNT_W'(1)) next_state = READY;
        default: next_state = IDLE;
      endcase
    end
  end

  // Rotating the doubled request vector puts the pointer slot at bit 0, so the scan is a plain priority search.
  assign req_dbl = {spawn_req, spawn_req};
  assign req_rot = req_dbl[ptr +: OBJ_NUM];

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < OBJ_NUM; i++) begin
      if (!found && req_rot[i]) begin
        found  = 1'b1;
        winner = PTR_W'((int'(ptr) + i) % OBJ_NUM);
      end
    end
  end

  assign winner_onehot = OBJ_NUM'(1) << winner;

  // One conditional subtraction folds the 10-bit raw value into range because 1023 < 2*RANGE.
  assign raw          = lfsr_value[9:0];
  assign x_offset     = (raw >= 10'(RANGE)) ? raw - 10'(RANGE) : raw;
  assign y_sum        = {3'b000, lfsr_value[12:10]} + {3'b000, level};
  assign y_speed_next = (y_sum > 6'd31) ? 5'd31 : y_sum[4:0];
  assign ceff         = CNT_W'(calc_ceff(COOLDOWN, int'(level)));

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      spawn_grant   <= '0;
      spawn_x       <= 10'(X_MIN);
      spawn_y_speed <= '0;
      spawn_x_speed <= '0;
      spawn_sign    <= 1'b0;
      ptr           <= '0;
      counter       <= '0;
    end else begin
      spawn_grant <= '0;
      if (enable && state == READY && found) begin
        spawn_grant   <= winner_onehot;
        spawn_x       <= 10'(X_MIN) + x_offset;
        spawn_y_speed <= y_speed_next;
        spawn_x_speed <= {3'b000, lfsr_value[14:13]};
        spawn_sign    <= lfsr_value[15];
        ptr           <= PTR_W'((int'(winner) + 1) % OBJ_NUM);
      end
      if (enable && state == GRANT)     counter <= ceff;
      else if (enable && state == HOLD) counter <= counter - CNT_W'(1);
    end
  end

  assign hit_counted = enable && bullet_hit && (kill_count != 8'hFF);

  always_ff @(posedge frame_clk) begin
    if (Reset)            kill_count <= '0;
    else if (hit_counted) kill_count <= kill_count + 8'd1;
  end

`ifdef SPAWN_DIFFICULTY_EN
  // The level steps on the hit that lands the counter exactly on a multiple of KILLS_PER_LEVEL.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      level <= '0;
    end else if (hit_counted && ((int'(kill_count) + 1) % KILLS_PER_LEVEL == 0)
                 && (level < 3'(MAX_LEVEL))) begin
      level <= level + 3'd1;
    end
  end
`else
  assign level = 3'd0;
`endif

endmodule

// File: tb/tb_meteor_spawn_scheduler.sv
// Randomized self-checking bench for meteor_spawn_scheduler against a time-slot reference model.
// Honours SPAWN_DIFFICULTY_EN the same way the design does.
module tb_meteor_spawn_scheduler;

  localparam int OBJ_NUM         = 4;
  localparam int COOLDOWN        = 8;
  localparam int X_MIN           = 25;
  localparam int X_MAX           = 605;
  localparam int KILLS_PER_LEVEL = 8;
  localparam int MAX_LEVEL       = 7;
  localparam int RANGE           = X_MAX - X_MIN + 1;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       enable;
  logic [3:0] spawn_req;
  logic       bullet_hit;
  logic [3:0] spawn_grant;
  logic [9:0] spawn_x;
  logic [4:0] spawn_y_speed;
  logic [4:0] spawn_x_speed;
  logic       spawn_sign;
  logic [2:0] level;
  logic [7:0] kill_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  // Reference model: instead of tracking FSM states it remembers the earliest edge at which a grant may occur.
  logic [15:0] m_lfsr;
  bit          m_running;
  int          m_ready_at;
  int          m_ptr;
  int          m_kills;
  int          m_grant;
  int          m_x;
  int          m_ys;
  int          m_xs;
  int          m_sign;

  meteor_spawn_scheduler #(
    .OBJ_NUM         (OBJ_NUM),
    .COOLDOWN        (COOLDOWN),
    .X_MIN           (X_MIN),
    .X_MAX           (X_MAX),
    .KILLS_PER_LEVEL (KILLS_PER_LEVEL),
    .MAX_LEVEL       (MAX_LEVEL)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .enable        (enable),
    .spawn_req     (spawn_req),
    .bullet_hit    (bullet_hit),
    .spawn_grant   (spawn_grant),
    .spawn_x       (spawn_x),
    .spawn_y_speed (spawn_y_speed),
    .spawn_x_speed (spawn_x_speed),
    .spawn_sign    (spawn_sign),
    .level         (level),
    .kill_count    (kill_count)
  );

  always #5 frame_clk = ~frame_clk;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting right.
  function automatic logic [15:0] nextLfsr(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  function automatic int modelLevel(input int kills);
`ifdef SPAWN_DIFFICULTY_EN
    return (kills / KILLS_PER_LEVEL > MAX_LEVEL) ? MAX_LEVEL : kills / KILLS_PER_LEVEL;
`else
    return 0;
`endif
  endfunction

  function automatic int modelCeff(input int lvl);
    return (COOLDOWN - lvl < 1) ? 1 : COOLDOWN - lvl;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
    end
  endtask

  task automatic modelEdge(input logic rst, input logic en, input logic [3:0] req, input logic hit);
    int  old_level;
    int  winner;
    int  raw;
    bit  granted;
    if (rst) begin
      m_lfsr = 16'hACE1; m_running = 0; m_ready_at = 0; m_ptr = 0; m_kills = 0;
      m_grant = 0; m_x = X_MIN; m_ys = 0; m_xs = 0; m_sign = 0;
      return;
    end
    old_level = modelLevel(m_kills);
    granted   = 0;
    m_grant   = 0;
    if (!en) begin
      m_running = 0;
    end else if (!m_running) begin
      m_running  = 1;
      m_ready_at = cycle + 1;
    end else if (cycle >= m_ready_at && req != 4'b0000) begin
      winner = -1;
      for (int k = 0; k < OBJ_NUM; k++) begin
        if (winner < 0 && req[(m_ptr + k) % OBJ_NUM]) winner = (m_ptr + k) % OBJ_NUM;
      end
      m_grant = 1 << winner;
      m_ptr   = (winner + 1) % OBJ_NUM;
      raw     = int'(m_lfsr) % 1024;
      m_x     = X_MIN + raw % RANGE;
      m_ys    = (int'(m_lfsr) / 1024) % 8 + old_level;
      if (m_ys > 31) m_ys = 31;
      m_xs    = (int'(m_lfsr) / 8192) % 4;
      m_sign  = int'(m_lfsr) / 32768;
      granted = 1;
    end
    if (en && hit && m_kills < 255) m_kills++;
    if (granted) m_ready_at = cycle + modelCeff(modelLevel(m_kills)) + 2;
    m_lfsr = nextLfsr(m_lfsr);
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, then compare just after it.
  task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] req, input logic hit);
    Reset      = rst;
    enable     = en;
    spawn_req  = req;
    bullet_hit = hit;
    @(posedge frame_clk);
    modelEdge(rst, en, req, hit);
    cycle++;
    #1;
    checkOutput("spawn_grant",   32'(spawn_grant),    32'(m_grant));
    checkOutput("spawn_x",       32'(spawn_x),        32'(m_x));
    checkOutput("spawn_y_speed", 32'(spawn_y_speed),  32'(m_ys));
    checkOutput("spawn_x_speed", 32'(spawn_x_speed),  32'(m_xs));
    checkOutput("spawn_sign",    32'(spawn_sign),     32'(m_sign));
    checkOutput("level",         32'(level),          32'(modelLevel(m_kills)));
    checkOutput("kill_count",    32'(kill_count),     32'(m_kills));
    checkOutput("lfsr",          32'(dut.lfsr_value), 32'(m_lfsr));
  endtask

  initial begin
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       hit;

    Reset = 1'b1; enable = 1'b0; spawn_req = 4'b0000; bullet_hit = 1'b0;
    repeat (2) applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);

    repeat (25) applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0);
    repeat (45) applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);

    // Drop enable while the scheduler is cooling down, then come back with a single request.
    repeat (3)  applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
    repeat (6)  applyStimulus(1'b0, 1'b0, 4'b1111, 1'b0);
    repeat (14) applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0);

    repeat (8)  applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1);
    repeat (30) applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0);

    req = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      rst = (n == 2000);
      en  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      hit = ($urandom_range(0, 3) == 0);
      applyStimulus(rst, en, req, hit);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/meteor_spawn_scheduler.md
# meteor_spawn_scheduler

Arbitrates respawn requests from the `OBJ_NUM` meteorite slots of the obstacle datapath and grants at most one spawn per frame. Each grant carries a pseudo-random spawn position, speed and direction. Spawns are spaced by a cooldown counter, and a difficulty level ramps with kills. The block sits between the game state machine, via `enable`, and the obstacle array, where each slot raises `spawn_req` when deactivated or out of bounds.

## Interface
- `OBJ_NUM`, 4: number of meteorite slots.
- `COOLDOWN`, 8: base frames between grants; must be ≥1.
- `X_MIN`, 25: leftmost spawn x.
- `X_MAX`, 605: rightmost spawn x.
- `KILLS_PER_LEVEL`, 8: kills per difficulty step.
- `MAX_LEVEL`, 7: level saturation value; must be ≤7.
- `frame_clk` in 1: the single clock, one edge per video frame.
- `Reset` in 1: synchronous, active-high.
- `enable` in 1: game running; low forces IDLE.
- `spawn_req` in [OBJ_NUM]: per-slot request, level-sensitive, held until granted.
- `bullet_hit` in 1: one-cycle kill pulse.
- `spawn_grant` out [OBJ_NUM]: one-hot grant, one cycle wide.
- `spawn_x` out 10: spawn x position.
- `spawn_y_speed` out 5: vertical speed increment.
- `spawn_x_speed` out 5: horizontal speed magnitude.
- `spawn_sign` out 1: 1 = move left.
- `level` out 3: current difficulty level.
- `kill_count` out 8: saturating kill counter.

## Operation
- **Reset values:**
  - Outputs: `spawn_grant` 0, `spawn_x` = `X_MIN`, speeds 0, `spawn_sign` 0, `level` 0, `kill_count` 0.
  - Internal: state IDLE, round-robin pointer 0, LFSR = 16'hACE1.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle when not in reset, independent of `enable`.
- **States:**
  - IDLE: if `enable` then READY.
  - READY: if any `spawn_req` then GRANT, else stay.
  - GRANT: then HOLD, with counter = Ceff.
  - HOLD: decrement the counter; at 0 go to READY.
  - `enable` low in any state: IDLE on the next edge. This wins over all other transitions.
- **Arbitration:** on the READY→GRANT edge, select the first asserted request at or after the pointer, searching upward and wrapping. Register the one-hot grant and the payload. Set pointer = winner+1 mod `OBJ_NUM`.
- **Request timing:** a request deasserted before the READY evaluation is not granted. Requests are ignored in GRANT, HOLD and IDLE.
- **Payload:** computed from the LFSR value at the evaluation edge.
  - raw = lfsr[9:0]; R = `X_MAX`−`X_MIN`+1.
  - `spawn_x` = `X_MIN` + (raw ≥ R ? raw−R : raw). A single subtraction is valid because 1023 < 2R.
  - `spawn_y_speed` = lfsr[12:10] + `level`, 5-bit, saturating at 31.
  - `spawn_x_speed` = lfsr[14:13].
  - `spawn_sign` = lfsr[15].
- **Payload hold:** the payload stays stable until the next grant. The obstacle array samples it when its grant bit is 1.
- **Kills:** `kill_count` increments on `bullet_hit` only while `enable` is high, saturating at 255. `bullet_hit` is independent of arbitration; a hit and a grant in the same cycle are both honoured.
- **Ceff:** `COOLDOWN` − `level`, clamped to a minimum of 1.

## Timing
- Request to grant: `spawn_grant` goes high on the edge after READY samples the request, so latency is 1 cycle from READY.
- Grant width: exactly 1 cycle. `spawn_grant` is cleared on the GRANT→HOLD edge, or by `enable` low.
- Grant spacing: minimum Ceff+2 cycles (GRANT, Ceff HOLD cycles, READY).
- Worst-case wait for a persistently requesting slot: `OBJ_NUM`·(Ceff+2) cycles.
- `Reset` mid-operation: all state and outputs return to reset values on that edge. An in-flight grant is dropped.
- `enable` falling: `spawn_grant` is 0 from the next edge. The pointer and `kill_count` are retained; the counter restarts on re-entry.

## Configuration
- `SPAWN_DIFFICULTY_EN` defined:
  - `level` increments each time `kill_count` crosses a multiple of `KILLS_PER_LEVEL`, saturating at `MAX_LEVEL`.
  - `level` feeds `spawn_y_speed` and Ceff.
- `SPAWN_DIFFICULTY_EN` undefined:
  - `level` is tied to 0, Ceff = `COOLDOWN`, and no level logic is synthesized.
  - `kill_count` is still maintained.

## Structure
- Package `spawn_pkg` holds:
  - the state enum (IDLE, READY, GRANT, HOLD);
  - the LFSR seed and tap constants;
  - the default `X_MIN`/`X_MAX` values.
- Sub-module `spawn_lfsr`: a 16-bit free-running LFSR with synchronous reset to the seed.
- The arbiter, FSM, counters and payload mapping stay in the top module.

## Test plan
- Reset asserted for 2 cycles → all outputs at reset values, LFSR reads 16'hACE1.
- `enable`=1, `spawn_req`=4'b0100 held → `spawn_grant`=4'b0100 for 1 cycle, `spawn_x` in [25,605], then no grant for 9 cycles even with the request still high. The next grant comes at cycle 10 (spacing Ceff+2 = 10, Ceff = 8, level 0).
- `spawn_req`=4'b1111 held → grant order 0001, 0010, 0100, 1000, 0001, spaced 10 cycles apart at level 0.
- Force raw = 600 via LFSR state → `spawn_x` = 44. Force raw = 100 → `spawn_x` = 125.
- `enable` dropped during HOLD → no grant for the rest of the test. Re-enable with `spawn_req`=0001 → grant 0001 two cycles later (IDLE→READY→GRANT).
- 8 `bullet_hit` pulses → `kill_count`=8. With the macro: `level`=1, `spawn_y_speed` = lfsr[12:10]+1, next spacing 9 cycles. Without the macro: `level`=0.
